vga_stream_out: RTL and testbench
=================================

# vga_stream_out

Downstream VGA output stage for the face/filter pixel source. It consumes the 640x480 Avalon-ST pixel stream (30-bit RGB, startofpacket/endofpacket), buffers it in a small FIFO, and generates 640x480@60 raster timing from the system clock via a pixel-enable divider. It aligns each stream packet to the raster origin and drives the VGA DAC pins. It recovers automatically from underflow and misaligned packets by flushing and re-aligning on the next startofpacket.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch (lines)
- CLK_DIV, 2, clk cycles per pixel (≥2)
- FIFO_DEPTH, 16, pixel FIFO entries (power of 2)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- data  in  30  pixel {R[29:20], G[19:10], B[9:0]}
- startofpacket  in  1  first pixel of frame
- endofpacket  in  1  last pixel of frame (ignored for alignment)
- valid  in  1  data valid
- ready  out  1  sink can accept
- vga_r / vga_g / vga_b  out  8  colour, upper 8 bits of each 10-bit channel
- vga_hs / vga_vs  out  1  syncs, active low
- vga_blank_n  out  1  high in active area
- vga_sync_n  out  1  constant 0
- vga_clk  out  1  pixel clock to DAC
- underflow_count  out  16  saturating count of underflow/misalign events

## Operation
- Divider: div_cnt counts 0..CLK_DIV-1; pix_en = (div_cnt == CLK_DIV-1); vga_clk = (div_cnt >= CLK_DIV/2).
- Raster: on pix_en, h_cnt 0..H_TOTAL-1 (800), then wraps and advances v_cnt 0..V_TOTAL-1 (525); both wrap to 0 at (799,524).
- Active = h_cnt<640 && v_cnt<480. hs low for 656≤h<752; vs low for 490≤v<492.
- FIFO stores {sop, data}. Write on valid&&ready. ready = ~reset && (state==ALIGN || !full).
- State ALIGN: FIFO empty; ready=1; non-sop words are dropped; valid&&sop is written and state goes to WAIT_FRAME.
- State WAIT_FRAME: fill the FIFO; output black. On pix_en with (h,v)==(0,0), go to STREAM and pop the head (which is the sop word).
- State STREAM: on every pix_en in the active area, pop one entry and display it.
- Error 1: FIFO empty on a required pop. Output black, increment underflow_count, flush, go to ALIGN.
- Error 2: popped head has sop=1 at (h,v)≠(0,0). Same action as error 1.
- Error 3: at (0,0) the head has sop=0. Same action as error 1.
- Flush and a write in the same cycle: flush wins; the write is dropped unless it is a sop word, which starts ALIGN→WAIT_FRAME immediately.
- Simultaneous write and pop on the same cycle are both performed; occupancy is unchanged.
- underflow_count saturates at 0xFFFF.

## Timing
- Reset values:
  - vga_r/g/b = 0, vga_hs = vga_vs = 1, vga_blank_n = 0, vga_sync_n = 0, vga_clk = 0
  - ready = 0, underflow_count = 0
  - counters 0, state ALIGN, FIFO empty
- Reset mid-frame returns all of the above on the next edge.
- All VGA outputs are registered and update on the clk edge following the pix_en cycle. hs, vs, blank and colour are mutually aligned (same one-cycle latency).
- Outputs hold for CLK_DIV cycles.
- FIFO write-to-pop latency ≥1 clk: a word written in cycle n is poppable in cycle n+1.
- Colour is forced to 0 whenever blank_n=0 or the state is not STREAM.
- Sustained throughput: one word per pix_en during active area; upstream is backpressured via ready when the FIFO is full.

## Test plan
- Reset then continuous valid source with sop on pixel 0 → first visible pixel at (0,0) equals the sop word's data[29:22]; 307200 pixels are shown per frame; underflow_count stays 0 over 3 frames.
- Raster check with CLK_DIV=2 → hs low for 192 clk per 1600-clk line; vs low for 2 lines per 525; blank_n high exactly 640 pixels × 480 lines.
- Leading garbage: 5 non-sop words before first sop → garbage dropped with ready=1 throughout; display starts with the sop word at (0,0).
- Stall source (valid=0) for 40 pixel times mid-frame → black output, underflow_count=1, resumes correctly from the next sop at the following (0,0).
- Early sop inserted at pixel 1000 → underflow_count increments; the next frame aligns correctly.
- Assert reset for 1 cycle mid-line → all outputs at reset values the next edge; normal stream resumes on the next sop.

Source files
------------

// File: rtl/vga_stream_out.sv
// VGA output stage: buffers a 30-bit Avalon-ST pixel stream, aligns each packet to the
// raster origin and generates sync/blank timing from a clock-enable divider.
module vga_stream_out #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] data,
  input  logic        startofpacket,
  input  logic        endofpacket,
  input  logic        valid,
  output logic        ready,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic        vga_clk,
  output logic [15:0] underflow_count
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ALIGN, WAIT_FRAME, STREAM} state_t;

  state_t          state_r;
  logic [DW-1:0]   div_cnt_r;
  logic [HW-1:0]   h_cnt_r;
  logic [VW-1:0]   v_cnt_r;
  logic [30:0]     mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     count_r;

  logic            pix_en_s;
  logic            at_origin_s;
  logic            active_s;
  logic            empty_s;
  logic            full_s;
  logic [30:0]     head_s;
  logic            wr_fire_s;
  logic            sop_wr_s;
  logic            need_pop_s;
  logic            err_s;
  logic            pop_s;
  logic            mem_we_s;
  logic [AW-1:0]   mem_waddr_s;
  logic            unused_s;

  assign pix_en_s    = (div_cnt_r == DW'(CLK_DIV - 1));
  assign at_origin_s = (h_cnt_r == HW'(0)) && (v_cnt_r == VW'(0));
  assign active_s    = (h_cnt_r < HW'(H_ACTIVE)) && (v_cnt_r < VW'(V_ACTIVE));
  assign empty_s     = (count_r == (AW+1)'(0));
  assign full_s      = (count_r == (AW+1)'(FIFO_DEPTH));
  assign head_s      = mem_r[rd_ptr_r];
  assign ready       = ~reset && ((state_r == ALIGN) || !full_s);
  assign wr_fire_s   = valid && ready;
  assign sop_wr_s    = wr_fire_s && startofpacket;
  assign vga_sync_n  = 1'b0;
  assign vga_clk     = (div_cnt_r >= DW'(CLK_DIV / 2));
  assign unused_s    = ^{endofpacket, head_s[21:20], head_s[11:10], head_s[1:0]};

  // Pop request, error detection and FIFO write steering
  always_comb begin
    need_pop_s  = 1'b0;
    case (state_r)
      WAIT_FRAME: need_pop_s = pix_en_s && at_origin_s;
      STREAM:     need_pop_s = pix_en_s && active_s;
      default:    need_pop_s = 1'b0;
    endcase
    // A sop head is legal only at the origin, and the origin demands a sop head.
    err_s = need_pop_s && (empty_s || (head_s[30] != at_origin_s));
    pop_s = need_pop_s && !err_s;
    if (err_s || (state_r == ALIGN)) begin
      mem_we_s    = sop_wr_s;
      mem_waddr_s = AW'(0);
    end else begin
      mem_we_s    = wr_fire_s;
      mem_waddr_s = wr_ptr_r;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= {startofpacket, data};
    end
  end

  // Pixel-enable divider and raster counters
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_r <= DW'(0);
      h_cnt_r   <= HW'(0);
      v_cnt_r   <= VW'(0);
    end else if (pix_en_s) begin
      div_cnt_r <= DW'(0);
      if (h_cnt_r == HW'(H_TOTAL - 1)) begin
        h_cnt_r <= HW'(0);
        v_cnt_r <= (v_cnt_r == VW'(V_TOTAL - 1)) ? VW'(0) : v_cnt_r + VW'(1);
      end else begin
        h_cnt_r <= h_cnt_r + HW'(1);
      end
    end else begin
      div_cnt_r <= div_cnt_r + DW'(1);
    end
  end

  // Alignment state, FIFO pointers and error counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= ALIGN;
      wr_ptr_r        <= AW'(0);
      rd_ptr_r        <= AW'(0);
      count_r         <= (AW+1)'(0);
      underflow_count <= 16'h0000;
    end else if (err_s) begin
      rd_ptr_r <= AW'(0);
      if (underflow_count != 16'hFFFF) begin
        underflow_count <= underflow_count + 16'h0001;
      end
      if (sop_wr_s) begin
        wr_ptr_r <= AW'(1);
        count_r  <= (AW+1)'(1);
        state_r  <= WAIT_FRAME;
      end else begin
        wr_ptr_r <= AW'(0);
        count_r  <= (AW+1)'(0);
        state_r  <= ALIGN;
      end
    end else if (state_r == ALIGN) begin
      if (sop_wr_s) begin
        wr_ptr_r <= AW'(1);
        count_r  <= (AW+1)'(1);
        state_r  <= WAIT_FRAME;
      end
    end else begin
      if (wr_fire_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + (AW+1)'(wr_fire_s) - (AW+1)'(pop_s);
      if (pop_s && (state_r == WAIT_FRAME)) begin
        state_r <= STREAM;
      end
    end
  end

  // Registered VGA outputs, updated once per pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
    end else if (pix_en_s) begin
      vga_hs      <= !((h_cnt_r >= HW'(H_ACTIVE + H_FP)) && (h_cnt_r < HW'(H_ACTIVE + H_FP + H_SYNC)));
      vga_vs      <= !((v_cnt_r >= VW'(V_ACTIVE + V_FP)) && (v_cnt_r < VW'(V_ACTIVE + V_FP + V_SYNC)));
      vga_blank_n <= active_s;
      if (pop_s) begin
        vga_r <= head_s[29:22];
        vga_g <= head_s[19:12];
        vga_b <= head_s[9:2];
      end else begin
        vga_r <= 8'h00;
        vga_g <= 8'h00;
        vga_b <= 8'h00;
      end
    end
  end
endmodule

// File: tb/tb_vga_stream_out.sv
// Directed bench for vga_stream_out on a reduced 8x4 raster: alignment, raster timing,
// garbage drop, underflow, early sop and mid-frame reset recovery.
module tb_vga_stream_out;
  localparam int HA = 8, HFP = 2, HSY = 3, HBP = 2;
  localparam int VA = 4, VFP = 1, VSY = 2, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int NPIX = HA * VA;
  localparam int FRAME_CLK = HT * VT * 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [29:0] data = 30'h0;
  logic        startofpacket = 1'b0;
  logic        endofpacket = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk;
  logic [15:0] underflow_count;

  int total = 0;
  int bad = 0;

  vga_stream_out #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .CLK_DIV(2), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .data(data), .startofpacket(startofpacket),
    .endofpacket(endofpacket), .valid(valid), .ready(ready),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n), .vga_clk(vga_clk),
    .underflow_count(underflow_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] pix_word(input int f, input int i);
    logic [7:0] fi, ii;
    fi = 8'(f);
    ii = 8'(i);
    return {ii, 2'b00, fi, 2'b00, ii ^ 8'hA5, 2'b11};
  endfunction

  // Source model: frames of NPIX words, optional garbage, stall and early sop
  int src_frame = 0, src_idx = 0, garbage_left = 0, stall_cnt = 0;
  int stall_frame = -1, early_frame = -1;
  bit src_on = 1'b0;
  bit fire = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (fire) begin
        if (garbage_left > 0) begin
          garbage_left--;
        end else begin
          src_idx++;
          if (src_idx == NPIX) begin
            src_idx = 0;
            src_frame++;
          end
          if (src_frame == early_frame && src_idx == 20) begin
            src_idx = 0;
            src_frame++;
            early_frame = -1;
          end
          if (src_frame == stall_frame && src_idx == 16) begin
            stall_cnt = 80;
            stall_frame = -1;
          end
        end
      end
      if (!src_on || stall_cnt > 0) begin
        valid = 1'b0;
        if (stall_cnt > 0) stall_cnt--;
      end else if (garbage_left > 0) begin
        valid = 1'b1;
        data = {8'hEE, 22'h0};
        startofpacket = 1'b0;
        endofpacket = 1'b0;
        chk("garbage_ready", {31'h0, ready}, 32'h1);
      end else begin
        valid = 1'b1;
        data = pix_word(src_frame, src_idx);
        startofpacket = (src_idx == 0);
        endofpacket = (src_idx == NPIX - 1);
      end
      fire = valid && ready;
    end
  end

  // Monitor: one sample per pixel while vga_clk is high; checks raster and captures frames
  int n = 0;
  int frames_done = 0;
  int act_cnt = 0, snap_act = 0;
  logic [7:0] px_r [NPIX], px_g [NPIX], px_b [NPIX];
  logic [7:0] snap_r [NPIX], snap_g [NPIX], snap_b [NPIX];

  always @(posedge clk) begin
    #1;
    if (reset) begin
      n = 0;
      act_cnt = 0;
    end else if (vga_clk) begin
      if (n == 0) begin
        chk("pre_pixel", {28'h0, vga_hs, vga_vs, vga_blank_n, vga_sync_n}, 32'hC);
      end else begin
        int k, h, v;
        logic ehs, evs, ebl;
        k = n - 1;
        h = k % HT;
        v = (k / HT) % VT;
        ehs = !(h >= HA + HFP && h < HA + HFP + HSY);
        evs = !(v >= VA + VFP && v < VA + VFP + VSY);
        ebl = (h < HA) && (v < VA);
        chk($sformatf("raster h=%0d v=%0d", h, v),
            {28'h0, vga_hs, vga_vs, vga_blank_n, vga_sync_n}, {28'h0, ehs, evs, ebl, 1'b0});
        if (!vga_blank_n) begin
          chk("blank_colour", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
        end else if (ebl) begin
          px_r[v * HA + h] = vga_r;
          px_g[v * HA + h] = vga_g;
          px_b[v * HA + h] = vga_b;
          act_cnt++;
        end
        if (h == HT - 1 && v == VT - 1) begin
          snap_r = px_r;
          snap_g = px_g;
          snap_b = px_b;
          snap_act = act_cnt;
          act_cnt = 0;
          frames_done++;
        end
      end
      n++;
    end
  end

  task automatic wait_frames(input int target);
    int t = 0;
    while (frames_done < target && t < 4 * FRAME_CLK) begin
      @(posedge clk);
      t++;
    end
    chk($sformatf("frame_wait %0d", target), {31'h0, frames_done >= target}, 32'h1);
    #2;
  endtask

  task automatic check_frame(input string tag, input int g, input int ngood);
    chk({tag, " active_px"}, 32'(snap_act), 32'(NPIX));
    for (int i = 0; i < NPIX; i++) begin
      logic [23:0] e;
      e = (i < ngood) ? {8'(i), 8'(g), 8'(i) ^ 8'hA5} : 24'h0;
      chk($sformatf("%s px%0d", tag, i), {8'h0, snap_r[i], snap_g[i], snap_b[i]}, {8'h0, e});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " ready"}, {31'h0, ready}, 32'h0);
    chk({tag, " syncs"}, {27'h0, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk}, 32'h18);
    chk({tag, " colour"}, {8'h0, vga_r, vga_g, vga_b}, 32'h0);
    chk({tag, " underflow"}, {16'h0, underflow_count}, 32'h0);
  endtask

  int sf, ef, rf, fd0, t;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    // Leading garbage, then continuous frames
    @(negedge clk);
    garbage_left = 5;
    reset = 1'b0;
    src_on = 1'b1;
    wait_frames(1);
    check_frame("f0_black", 0, 0);
    wait_frames(2);
    check_frame("f1", 0, NPIX);
    wait_frames(3);
    check_frame("f2", 1, NPIX);
    wait_frames(4);
    check_frame("f3", 2, NPIX);
    chk("uf_after_3", {16'h0, underflow_count}, 32'h0);

    // Stall the source for 40 pixel times inside the next source frame
    sf = src_frame + 1;
    stall_frame = sf;
    wait_frames(5);
    check_frame("pre_stall", sf - 1, NPIX);
    wait_frames(6);
    check_frame("stall", sf, 16);
    chk("uf_stall", {16'h0, underflow_count}, 32'h1);
    wait_frames(7);
    check_frame("post_stall", sf + 1, NPIX);

    // Early sop at pixel 20
    ef = src_frame + 1;
    early_frame = ef;
    wait_frames(8);
    check_frame("pre_early", ef - 1, NPIX);
    wait_frames(9);
    check_frame("early", ef, 20);
    chk("uf_early", {16'h0, underflow_count}, 32'h2);
    wait_frames(10);
    check_frame("post_early", ef + 2, NPIX);

    // One-cycle reset mid-frame
    t = 0;
    while (src_idx != 12 && t < 4 * FRAME_CLK) begin
      @(negedge clk);
      #2;
      t++;
    end
    chk("mid_wait", {31'h0, src_idx == 12}, 32'h1);
    rf = src_frame;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_reset");
    fd0 = frames_done;
    @(negedge clk);
    reset = 1'b0;
    wait_frames(fd0 + 1);
    check_frame("rst_black", 0, 0);
    wait_frames(fd0 + 2);
    check_frame("rst_resume", rf + 1, NPIX);
    chk("uf_reset", {16'h0, underflow_count}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
